fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage with its IF/ID pipeline register. Holds the program counter, presents it to a combinationally-read instruction memory, and registers the fetched word, its PC and PC+4 for decode. Drives `control_kill` to the downstream `instruction_kill` block, which substitutes the NOP whenever IF/ID holds a bubble. Handles pipeline stall, branch/jump redirect, and keeps fetch/flush statistics.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded by reset.
- `NOP`, 32'h0000_0013: instruction word placed in IF/ID on a bubble.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall` in 1: hazard unit holds the PC and IF/ID.
- `redirect` in 1: taken branch/jump resolved downstream.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_addr` out 32: current PC, equal to the PC register.
- `imem_rdata` in 32: instruction at `imem_addr`, valid in the same cycle.
- `if_id_instr` out 32: registered instruction.
- `if_id_pc` out 32: PC of `if_id_instr`.
- `if_id_pc_plus4` out 32: `if_id_pc` + 4.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `control_kill` out 1: `~if_id_valid`, registered; feeds `instruction_kill`.
- `fetch_count` out 32: valid instructions loaded into IF/ID.
- `flush_count` out 32: redirects taken.

## Operation
- Reset (`rst_n`=0 at an edge) sets: PC=`RESET_PC`; `if_id_instr`=`NOP`; `if_id_pc`=0; `if_id_pc_plus4`=0; `if_id_valid`=0; `control_kill`=1; both counters 0. Reset overrides every other input, including in mid-stall or mid-redirect.
- Each edge takes exactly one case, in this priority:
  - `redirect`=1:
    - PC <= {`redirect_pc`[31:2],2'b00}.
    - IF/ID <= bubble: instr=`NOP`, valid=0, kill=1, pc and pc_plus4 = current PC and PC+4.
    - `flush_count`++.
    - Redirect wins over `stall`.
  - `stall`=1: PC, IF/ID, valid, kill and counters all hold.
  - Otherwise:
    - PC <= PC+4.
    - IF/ID <= {`imem_rdata`, PC, PC+4}, valid=1, kill=0.
    - `fetch_count`++.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000; no fault is raised.
- Counters wrap from 32'hFFFF_FFFF to 0.

## Timing
- Fetch latency: PC presented in cycle N; its instruction appears on `if_id_*` in cycle N+1.
- First instruction after reset release:
  - Cycle after release: `imem_addr`=`RESET_PC`, IF/ID is a bubble.
  - One cycle later: IF/ID holds mem[`RESET_PC`] with valid=1.
- Redirect asserted in cycle N:
  - Cycle N+1: IF/ID is a bubble (`control_kill`=1) and `imem_addr`=target.
  - Cycle N+2: target instruction is in IF/ID.
  - Wrong-path penalty is one bubble from this stage.
- Redirect in consecutive cycles: each one applies, and the last target wins. Bubbles continue until one cycle after the final redirect.
- Stall for K cycles: outputs are frozen for K cycles. The next unstalled edge loads mem[PC] where PC is the value held during the stall, so no instruction is lost or duplicated.
- All outputs are registered. `imem_addr` is the PC register, with no combinational path from inputs.

## Structure
- Shared package `pipeline_pkg` holds:
  - Constants: `NOP_INSTR` (32'h0000_0013), `DEFAULT_RESET_PC`, `INSTR_W`=32, `PC_W`=32.
  - Packed struct `if_id_t` {instr, pc, pc_plus4, valid}.
- Sub-module `if_id_reg` is the IF/ID register. Its controls are load, bubble and hold; it has synchronous active-low reset and outputs `control_kill`.
- The top level holds the PC register, the next-PC mux and the counters.

## Test plan
- Reset and sequential fetch:
  - Stimulus: reset with `RESET_PC`=0, memory mem[i]=i+0x100, release for 4 cycles.
  - Required: after the first bubble, IF/ID shows pc 0,4,8 with instr 0x100,0x101,0x102; `fetch_count`=3 at the end.
- Redirect:
  - Stimulus: redirect to 0x40 while PC=0x10.
  - Required: next cycle `control_kill`=1 with `if_id_instr`=0x13; the cycle after, `if_id_pc`=0x40 with instr=mem[0x40]; `flush_count`=1.
- Stall with simultaneous redirect:
  - Stimulus: `stall` for 3 cycles at PC=0x20, then `stall` and `redirect` to 0x80 together.
  - Required: outputs frozen for 3 cycles, then a bubble, then pc 0x80.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: IF/ID later shows pc 0xFFFF_FFFC with pc_plus4 0, followed by pc 0.
- Reset mid-stall and misaligned target:
  - Stimulus: assert `rst_n`=0 during a stall; then redirect to 0x43.
  - Required: reset returns all outputs to their reset values on that edge; PC becomes 0x40.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch/decode boundary of the pipeline.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle latency, bubble beats hold beats load.
// Hold freezes contents and kill; a bubble keeps the PC fields but forces NOP.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q,
  output logic   control_kill
);

  if_id_t ifid_q, ifid_d;
  logic   kill_q, kill_d;

  always_comb begin
    ifid_d = ifid_q;
    kill_d = kill_q;
    if (bubble) begin
      ifid_d.instr    = NOP;
      ifid_d.pc       = d.pc;
      ifid_d.pc_plus4 = d.pc_plus4;
      ifid_d.valid    = 1'b0;
      kill_d          = 1'b1;
    end else if (hold) begin
      ifid_d = ifid_q;
      kill_d = kill_q;
    end else if (load) begin
      ifid_d = d;
      kill_d = ~d.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q <= '{instr: NOP, pc: '0, pc_plus4: '0, valid: 1'b0};
      kill_q <= 1'b1;
    end else begin
      ifid_q <= ifid_d;
      kill_q <= kill_d;
    end
  end

  assign q            = ifid_q;
  assign control_kill = kill_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select and statistics; fetch latency one cycle.
// Stall freezes everything; redirect overrides stall and inserts a single bubble.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               control_kill,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
);

  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]     fetch_q, fetch_d, flush_q, flush_d;
  if_id_t          ifid_in, ifid_out;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    fetch_d = fetch_q;
    flush_d = flush_q;
    if (redirect) begin
      pc_d    = redirect_pc & ~32'h3;
      flush_d = flush_q + 32'd1;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      fetch_d = fetch_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      fetch_q <= fetch_d;
      flush_q <= flush_d;
    end
  end

  // Bubbles still record the PC that was squashed, which helps trace debug.
  assign ifid_in = '{instr: imem_rdata, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg #(.NOP(NOP)) u_if_id_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (~redirect & ~stall),
    .bubble       (redirect),
    .hold         (stall & ~redirect),
    .d            (ifid_in),
    .q            (ifid_out),
    .control_kill (control_kill)
  );

  assign imem_addr      = pc_q;
  assign if_id_instr    = ifid_out.instr;
  assign if_id_pc       = ifid_out.pc;
  assign if_id_pc_plus4 = ifid_out.pc_plus4;
  assign if_id_valid    = ifid_out.valid;
  assign fetch_count    = fetch_q;
  assign flush_count    = flush_q;

endmodule
